down_count_timer: RTL and testbench
===================================

DOWN_COUNT_TIMER -- requirements
Module: down_count_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter and load-value width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk2  input  1  clock; all state SHALL update on the falling edge of clk2.
REQ-003 The block SHALL have port reset2  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port load_valid  input  1  load request.
REQ-005 The block SHALL have port load_value  input  WIDTH  value to load, unsigned.
REQ-006 The block SHALL have port load_ready  output  1  block accepts a load this cycle.
REQ-007 The block SHALL have port start  input  1  begin counting, level-sampled on each falling edge.
REQ-008 The block SHALL have port enable  input  1  count gate; enable=0 holds q in RUN.
REQ-009 The block SHALL have port mode  input  1  0 = one-shot, 1 = auto-reload; sampled at each terminal event.
REQ-010 The block SHALL have port abort  input  1  force return to IDLE.
REQ-011 The block SHALL have port q  output  WIDTH  current count, registered.
REQ-012 The block SHALL have port tc  output  1  terminal-count pulse, registered.
REQ-013 The block SHALL have port busy  output  1  high in RUN.
REQ-014 The block SHALL have port done  output  1  high in DONE.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DONE; busy = (state==RUN), done = (state==DONE), load_ready = (state==IDLE or DONE), all decoded from state.
REQ-016 The block SHALL keep an internal WIDTH-bit reload register, written only by an accepted load.
REQ-017 Load accept = load_valid and load_ready at a falling edge: q and reload SHALL both take load_value; from DONE the state SHALL go to IDLE.
REQ-018 In IDLE, start=1 with effective count nonzero SHALL go to RUN; the effective count is load_value if a load is accepted on the same edge, else q.
REQ-019 In IDLE, start=1 with effective count zero SHALL be ignored: state stays IDLE, no tc.
REQ-020 In RUN, on an edge with enable=1 and q>1: q SHALL decrement by 1.
REQ-021 In RUN, on an edge with enable=1 and q==1, mode=0: q SHALL become 0, state DONE, tc=1.
REQ-022 In RUN, on an edge with enable=1 and q==1, mode=1: q SHALL take the reload value, state stays RUN, tc=1.
REQ-023 Auto-reload period SHALL therefore equal the reload value in enabled cycles; q SHALL never show 0 in auto-reload.
REQ-024 In RUN with enable=0, q, state and tc=0 SHALL hold unchanged; load_valid SHALL be ignored.
REQ-025 tc SHALL be high for exactly one clock period following the terminal edge and 0 on every other edge.
REQ-026 In DONE, start=1 without a load SHALL set q to the reload value and go to RUN; a load on the same edge takes priority and goes to IDLE.
REQ-027 abort=1 SHALL, on the next falling edge, set state to IDLE and tc to 0 and hold q, overriding start, load, enable and the terminal event.
REQ-028 q arithmetic SHALL be unsigned modulo 2^WIDTH; q SHALL never underflow below 0 (no wrap from 0 to all-ones).

Reset
REQ-029 reset2=1 SHALL immediately, without a clock edge, force state=IDLE, q=0, reload=0, tc=0; hence busy=0, done=0, load_ready=1.
REQ-030 reset2 asserted mid-count SHALL abandon the count; after deassertion the block SHALL wait for a new load.
REQ-031 While reset2=1, all inputs SHALL be ignored.

Verification
REQ-032 WIDTH=4, load 3, start, mode=0, enable=1 -> q 3,2,1,0 on successive falling edges; tc high one cycle with q=0; done=1.
REQ-033 Load 2, mode=1, enable=1 for 6 edges -> q 2,1,2,1,2,1; tc pulses on every second edge; busy stays 1.
REQ-034 Load 5, start, enable=0 for 3 edges mid-count -> q frozen for 3 edges, then resumes decrementing; total terminal latency 5+3 edges.
REQ-035 Load 0, start -> stays IDLE, q=0, no tc; load 15 and start on the same edge -> RUN with q=15.
REQ-036 Count from 7, abort on edge 2 -> IDLE with q=5; reset2 pulse mid-RUN between edges -> q=0, IDLE, tc=0 immediately.
REQ-037 Reach DONE after load 4, then start -> q=4, RUN; load and start together in DONE -> IDLE with new value.

Source files
------------

// File: rtl/down_count_timer.sv
// rtl/down_count_timer.sv - falling-edge down-counter with load handshake, one-shot and auto-reload modes
module down_count_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk2,
  input  logic             reset2,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             start,
  input  logic             enable,
  input  logic             mode,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             load_acc;
  logic [WIDTH-1:0] eff_count;

  always_ff @(negedge clk2 or posedge reset2) begin
    if (reset2) begin
      state_q  <= ST_IDLE;
      count_q  <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign load_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign load_acc   = load_valid && load_ready;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    tc_d      = 1'b0;
    eff_count = load_acc ? load_value : count_q;

    // abort wins over everything: q and reload are frozen, only state and tc change
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      if (load_acc) begin
        count_d  = load_value;
        reload_d = load_value;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (start && (eff_count != CNT_ZERO)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (enable) begin
            if (count_q > CNT_ONE) begin
              count_d = count_q - CNT_ONE;
            end else if (count_q == CNT_ONE) begin
              tc_d = 1'b1;
              if (mode) begin
                count_d = reload_q;
              end else begin
                count_d = CNT_ZERO;
                state_d = ST_DONE;
              end
            end else begin
              // q cannot be zero in RUN; park in DONE rather than wrap
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (load_acc) begin
            state_d = ST_IDLE;
          end else if (start && (reload_q != CNT_ZERO)) begin
            count_d = reload_q;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign q    = count_q;
  assign tc   = tc_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_down_count_timer.sv
// tb/tb_down_count_timer.sv - directed and random checks of down_count_timer against a behavioural model
module tb_down_count_timer;

  logic       clk2 = 1'b1;
  logic       reset2;
  logic       load_valid;
  logic [3:0] load_value;
  logic       load_ready;
  logic       start;
  logic       enable;
  logic       mode;
  logic       abort;
  logic [3:0] q;
  logic       tc;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // model: phase 0=idle 1=counting 2=finished
  int m_phase;
  int m_q;
  int m_rl;
  int m_tc;

  down_count_timer #(.WIDTH(4)) dut (
    .clk2(clk2), .reset2(reset2), .load_valid(load_valid), .load_value(load_value),
    .load_ready(load_ready), .start(start), .enable(enable), .mode(mode), .abort(abort),
    .q(q), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk2 = ~clk2;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"}, int'(q), m_q);
    check({tag, ".tc"}, int'(tc), m_tc);
    check({tag, ".busy"}, int'(busy), int'(m_phase == 1));
    check({tag, ".done"}, int'(done), int'(m_phase == 2));
    check({tag, ".ready"}, int'(load_ready), int'(m_phase != 1));
  endtask

  task automatic model_reset();
    m_phase = 0; m_q = 0; m_rl = 0; m_tc = 0;
  endtask

  task automatic tick(input string tag);
    bit acc;
    int nq;
    @(negedge clk2);
    acc = load_valid && (m_phase != 1);
    m_tc = 0;
    if (abort) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      nq = acc ? int'(load_value) : m_q;
      if (acc) begin m_q = nq; m_rl = nq; end
      if (start && nq != 0) m_phase = 1;
    end else if (m_phase == 1) begin
      if (enable) begin
        if (m_q == 1) begin
          m_tc = 1;
          if (mode) m_q = m_rl;
          else begin m_q = 0; m_phase = 2; end
        end else begin
          m_q = m_q - 1;
        end
      end
    end else begin
      if (acc) begin
        m_q = int'(load_value); m_rl = m_q; m_phase = 0;
      end else if (start && m_rl != 0) begin
        m_q = m_rl; m_phase = 1;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit lv, input int val, input bit st, input bit en, input bit md, input bit ab);
    load_valid = lv; load_value = 4'(val); start = st; enable = en; mode = md; abort = ab;
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset2 = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 reset2 = 1'b0;
  endtask

  initial begin
    reset2 = 1'b1;
    model_reset();
    set_in(1, 9, 1, 1, 0, 0);
    @(negedge clk2);
    #1 check_all("reset_hold");
    reset2 = 1'b0;

    set_in(1, 3, 1, 1, 0, 0);
    tick("os_load");
    check("os_load_q3", int'(q), 3);
    set_in(0, 0, 0, 1, 0, 0);
    tick("os_e1");
    tick("os_e2");
    tick("os_e3");
    check("os_tc_at0", int'(tc), 1);
    check("os_done", int'(done), 1);
    tick("os_tc_drop");

    set_in(1, 2, 1, 1, 1, 0);
    tick("dn_load_start");
    check("dn_to_idle", int'(load_ready && !busy), 1);
    set_in(0, 0, 1, 1, 1, 0);
    tick("ar_start");
    set_in(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) tick("ar_run");
    check("ar_busy", int'(busy), 1);
    set_in(0, 0, 0, 1, 1, 1);
    tick("ar_abort");

    set_in(1, 5, 1, 1, 0, 0);
    tick("en_load");
    set_in(0, 0, 0, 1, 0, 0);
    tick("en_e1");
    set_in(1, 11, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("en_frozen");
    check("en_hold_q4", int'(q), 4);
    set_in(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick("en_resume");
    check("en_terminal", int'(tc), 1);

    set_in(1, 0, 0, 1, 0, 0);
    tick("z_load");
    set_in(0, 0, 1, 1, 0, 0);
    tick("z_start");
    check("z_stay_idle", int'(busy), 0);
    set_in(1, 15, 1, 1, 0, 0);
    tick("f_load_start");
    check("f_q15", int'(q), 15);
    set_in(0, 0, 0, 1, 0, 1);
    tick("f_abort");

    set_in(1, 7, 1, 1, 0, 0);
    tick("ab_load");
    set_in(0, 0, 0, 1, 0, 0);
    tick("ab_e1");
    tick("ab_e2");
    set_in(0, 0, 1, 1, 0, 1);
    tick("ab_abort");
    check("ab_q5", int'(q), 5);
    set_in(1, 7, 1, 1, 0, 0);
    tick("rs_load");
    set_in(0, 0, 0, 1, 0, 0);
    tick("rs_e1");
    pulse_reset("rs_mid");
    tick("rs_after");

    set_in(1, 4, 1, 1, 0, 0);
    tick("dr_load");
    set_in(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick("dr_count");
    set_in(0, 0, 1, 1, 0, 0);
    tick("dr_restart");
    check("dr_q4", int'(q), 4);
    set_in(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick("dr_count2");
    set_in(1, 9, 1, 1, 0, 0);
    tick("dr_load_prio");
    check("dr_q9", int'(q), 9);

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(3, 0) == 0, int'($urandom_range(15, 0)),
             $urandom_range(3, 0) == 0, $urandom_range(3, 0) != 0,
             $urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0);
      tick("rnd");
      if ($urandom_range(63, 0) == 0) pulse_reset("rnd_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
